// File: rtl/ula_nibble_sequencer.sv
// Runs WIDTH-bit ADD/SUB/ADC/SBC through one external NIB-bit adder slice,
// least-significant nibble first, and registers the result and N/C/V/Z flags.
module ula_nibble_sequencer #(
  parameter int NIB     = 4,
  parameter int NUM_NIB = 4,
  localparam int WIDTH  = NIB * NUM_NIB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [NIB-1:0]   nib_a,
  output logic [NIB-1:0]   nib_b,
  output logic             nib_cin,
  input  logic [NIB-1:0]   nib_sum,
  input  logic             nib_cout,
  output logic [WIDTH-1:0] result,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             done
);

  localparam int IW = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic             r_ready;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [IW-1:0]    r_idx;
  logic [NIB-1:0]   r_nib_a;
  logic [NIB-1:0]   r_nib_b;
  logic             r_nib_cin;
  logic [WIDTH-1:0] r_result;
  logic             r_n;
  logic             r_c;
  logic             r_v;
  logic             r_z;
  logic             r_done;

  logic [WIDTH-1:0] w_b_sel;
  logic             w_cin_init;
  logic [WIDTH-1:0] w_final_res;

  // op[0] selects subtraction (inverted B), op[1] selects the external carry
  assign w_b_sel     = op[0] ? ~b : b;
  assign w_cin_init  = op[1] ? carry_in : op[0];
  assign w_final_res = {nib_sum, r_result[WIDTH-NIB-1:0]};

  // Operands shift down one nibble per step so the slice inputs can be
  // registered one cycle ahead; the slice carry chains through r_nib_cin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_a       <= '0;
      r_b       <= '0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      r_idx     <= '0;
      r_nib_a   <= '0;
      r_nib_b   <= '0;
      r_nib_cin <= 1'b0;
      r_result  <= '0;
      r_n       <= 1'b0;
      r_c       <= 1'b0;
      r_v       <= 1'b0;
      r_z       <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a >> NIB;
            r_b       <= w_b_sel >> NIB;
            r_a_msb   <= a[WIDTH-1];
            r_b_msb   <= w_b_sel[WIDTH-1];
            r_nib_a   <= a[NIB-1:0];
            r_nib_b   <= w_b_sel[NIB-1:0];
            r_nib_cin <= w_cin_init;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[r_idx*NIB +: NIB] <= nib_sum;
          r_idx <= r_idx + IW'(1);
          if (r_idx == LAST_IDX) begin
            r_n       <= nib_sum[NIB-1];
            r_c       <= nib_cout;
            r_v       <= (r_a_msb == r_b_msb) && (nib_sum[NIB-1] != r_a_msb);
            r_z       <= (w_final_res == '0);
            r_done    <= 1'b1;
            r_nib_a   <= '0;
            r_nib_b   <= '0;
            r_nib_cin <= 1'b0;
            r_state   <= S_FIN;
          end else begin
            r_nib_a   <= r_a[NIB-1:0];
            r_nib_b   <= r_b[NIB-1:0];
            r_nib_cin <= nib_cout;
            r_a       <= r_a >> NIB;
            r_b       <= r_b >> NIB;
          end
        end
        S_FIN: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready   = r_ready;
  assign nib_a   = r_nib_a;
  assign nib_b   = r_nib_b;
  assign nib_cin = r_nib_cin;
  assign result  = r_result;
  assign N       = r_n;
  assign C       = r_c;
  assign V       = r_v;
  assign Z       = r_z;
  assign done    = r_done;

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// Bench for ula_nibble_sequencer: directed vector table, handshake and reset
// corner cases, then random operations against a whole-word arithmetic model.
module tb_ula_nibble_sequencer;

  localparam int NIB     = 4;
  localparam int NUM_NIB = 4;
  localparam int WIDTH   = NIB * NUM_NIB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ready;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             carry_in = 1'b0;
  logic [NIB-1:0]   nib_a;
  logic [NIB-1:0]   nib_b;
  logic             nib_cin;
  logic [NIB-1:0]   nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] result;
  logic             N, C, V, Z, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // External combinational adder slice
  assign {nib_cout, nib_sum} = {1'b0, nib_a} + {1'b0, nib_b} + {{NIB{1'b0}}, nib_cin};

  ula_nibble_sequencer #(.NIB(NIB), .NUM_NIB(NUM_NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .op(op),
    .a(a), .b(b), .carry_in(carry_in), .nib_a(nib_a), .nib_b(nib_b),
    .nib_cin(nib_cin), .nib_sum(nib_sum), .nib_cout(nib_cout),
    .result(result), .N(N), .C(C), .V(V), .Z(Z), .done(done)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_res;
    logic [3:0]  exp_nczv; // {N,C,V,Z}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole-word reference: unsigned sum gives C, exact signed sum gives V.
  function automatic logic [19:0] model(input logic [1:0] m_op, input logic [15:0] m_a,
                                        input logic [15:0] m_b, input logic m_cin);
    logic [15:0] bb;
    longint      ci, usum, ssum;
    logic [15:0] res;
    logic        fn, fc, fv, fz;
    bb   = m_op[0] ? ~m_b : m_b;
    ci   = m_op[1] ? longint'(m_cin) : longint'(m_op[0]);
    usum = longint'(m_a) + longint'(bb) + ci;
    ssum = longint'($signed(m_a)) + longint'($signed(bb)) + ci;
    res  = usum[15:0];
    fc   = (usum > 65535);
    fv   = (ssum > 32767) || (ssum < -32768);
    fn   = res[15];
    fz   = (res == 16'h0000);
    return {res, fn, fc, fv, fz};
  endfunction

  // One operation: waits for ready, accepts, then watches until ready returns.
  task automatic run_op(input logic [1:0] t_op, input logic [15:0] t_a, input logic [15:0] t_b,
                        input logic t_cin, input int intrude_at,
                        output logic [15:0] o_res, output logic [3:0] o_flags,
                        output int o_done_c, output int o_dones, output int o_ready_c,
                        output logic [3:0] o_cin_trace, output logic [3:0] o_nb0);
    int k;
    o_res = '0; o_flags = '0; o_done_c = -1; o_dones = 0; o_ready_c = -1;
    o_cin_trace = '0; o_nb0 = '0;
    k = 0;
    while (!ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!ready) begin
      chk("ready_wait_timeout", 32'(ready), 32'd1);
      return;
    end
    op = t_op; a = t_a; b = t_b; carry_in = t_cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); carry_in = 1'($urandom);
    for (int c = 1; c <= 12; c++) begin
      if (c <= NUM_NIB) begin
        o_cin_trace[c-1] = nib_cin;
        if (c == 1) o_nb0 = nib_b;
      end
      if (done) begin
        o_dones++;
        if (o_done_c < 0) begin
          o_done_c = c;
          o_res    = result;
          o_flags  = {N, C, V, Z};
        end
      end
      if (ready) begin
        o_ready_c = c;
        break;
      end
      if (c == intrude_at) begin
        start = 1'b1; a = 16'h5A5A; b = 16'h0F0F; op = 2'b01;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  vec_t        vecs[6];
  logic [15:0] r_res;
  logic [3:0]  r_flags, r_cins, r_nb0;
  int          r_done_c, r_dones, r_ready_c, dones_seen;
  logic [19:0] m;

  initial begin
    vecs[0] = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1010};
    vecs[1] = '{2'b01, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0101};
    vecs[2] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0101};
    vecs[3] = '{2'b10, 16'h0000, 16'h0000, 1'b1, 16'h0001, 4'b0000};
    vecs[4] = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0110};
    vecs[5] = '{2'b11, 16'h0005, 16'h0005, 1'b0, 16'hFFFF, 4'b1000};

    // Reset values while held in reset
    #3;
    chk("reset_outputs", 32'({result, N, C, V, Z, done, nib_a, nib_b, nib_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(ready), 32'd1);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, -1,
             r_res, r_flags, r_done_c, r_dones, r_ready_c, r_cins, r_nb0);
      $display("[TB] vec %0d op=%0d a=%h b=%h cin=%0d -> result=%h NCVZ=%b", i,
               vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r_res, r_flags);
      chk($sformatf("vec%0d_result", i), 32'(r_res), 32'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flags", i), 32'(r_flags), 32'(vecs[i].exp_nczv));
      chk($sformatf("vec%0d_done_cycle", i), 32'(r_done_c), 32'(NUM_NIB + 1));
      chk($sformatf("vec%0d_done_pulses", i), 32'(r_dones), 32'd1);
      chk($sformatf("vec%0d_ready_cycle", i), 32'(r_ready_c), 32'(NUM_NIB + 2));
      if (i == 0) chk("vec0_cin_trace", 32'(r_cins), 32'b1110);
      if (i == 1) chk("vec1_first_nib_b", 32'(r_nb0), 32'hB);
    end

    // Result and flags hold in IDLE
    @(posedge clk); #1;
    chk("hold_in_idle", 32'({result, N, C, V, Z, done}), 32'({16'hFFFF, 4'b1000, 1'b0}));

    // Start pulsed 2 cycles after accept is ignored
    run_op(2'b00, 16'h8000, 16'h0123, 1'b0, 2,
           r_res, r_flags, r_done_c, r_dones, r_ready_c, r_cins, r_nb0);
    $display("[TB] ignore-start txn -> result=%h NCVZ=%b dones=%0d", r_res, r_flags, r_dones);
    chk("ignore_result", 32'(r_res), 32'h8123);
    chk("ignore_flags", 32'(r_flags), 32'b1000);
    chk("ignore_dones", 32'(r_dones), 32'd1);
    chk("ignore_ready_cycle", 32'(r_ready_c), 32'(NUM_NIB + 2));
    dones_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) dones_seen++;
    end
    chk("ignore_no_second_op", 32'(dones_seen), 32'd0);

    // Reset during the 3rd RUN cycle
    op = 2'b00; a = 16'h1111; b = 16'h2222; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", 32'({result, N, C, V, Z, done, nib_a, nib_b, nib_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) dones_seen++;
    end
    chk("midrun_no_done", 32'(dones_seen), 32'd0);
    chk("midrun_ready", 32'(ready), 32'd1);
    $display("[TB] reset mid-RUN txn -> result=%h dones=%0d", result, dones_seen);
    run_op(2'b00, 16'h0003, 16'h0004, 1'b0, -1,
           r_res, r_flags, r_done_c, r_dones, r_ready_c, r_cins, r_nb0);
    $display("[TB] post-reset ADD 0003+0004 -> result=%h NCVZ=%b", r_res, r_flags);
    chk("post_reset_add", 32'(r_res), 32'h0007);
    chk("post_reset_flags", 32'(r_flags), 32'b0000);

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [15:0] ra, rb;
      logic        rc;
      rop = 2'($urandom); ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      m = model(rop, ra, rb, rc);
      run_op(rop, ra, rb, rc, (i % 3 == 0) ? 1 + (i % 5) : -1,
             r_res, r_flags, r_done_c, r_dones, r_ready_c, r_cins, r_nb0);
      $display("[TB] rand %0d op=%0d a=%h b=%h cin=%0d -> result=%h NCVZ=%b", i,
               rop, ra, rb, rc, r_res, r_flags);
      chk($sformatf("rand%0d_result", i), 32'(r_res), 32'(m[19:4]));
      chk($sformatf("rand%0d_flags", i), 32'(r_flags), 32'(m[3:0]));
      chk($sformatf("rand%0d_done", i), 32'({r_done_c[7:0], r_dones[7:0]}),
          32'({8'(NUM_NIB + 1), 8'd1}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
